// File: rtl/servo_frame_ctrl.sv
// ============================================================================
//  Module   : servo_frame_ctrl
//  Purpose  : Frame/position controller feeding a servo PWM stage. Generates a
//             prescaled frame counter, and updates the commanded position
//             once per frame, either tracking a handshaked target (rate
//             limited to STEP per frame) or sweeping between two bounds.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             run              - enable frame generation
//             sweep            - 1 = autonomous sweep, 0 = track target
//             tgt_deg/valid    - target offer (valid/ready)
//             tgt_ready        - 1-entry target buffer empty
//             cntr, deg, en    - frame counter, position, enable to PWM stage
//             frame_start      - one-cycle pulse when cntr wraps to 0
//             at_target        - deg equals the active target (tracking only)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module servo_frame_ctrl #(
    parameter int CNTR_WIDTH = 11,
    parameter int CLK_DIV    = 50,
    parameter int STEP       = 1,
    parameter int SWEEP_MIN  = 0,
    parameter int SWEEP_MAX  = 255,
    parameter int DEG_RESET  = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  sweep,
    input  logic [7:0]            tgt_deg,
    input  logic                  tgt_valid,
    output logic                  tgt_ready,
    output logic [CNTR_WIDTH-1:0] cntr,
    output logic [7:0]            deg,
    output logic                  en,
    output logic                  frame_start,
    output logic                  at_target
);

    localparam int              c_PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(CLK_DIV - 1);
    localparam logic [7:0]      c_STEP8      = 8'(STEP);
    localparam logic [9:0]      c_STEP10     = 10'(STEP);
    localparam logic [7:0]      c_SMIN       = 8'(SWEEP_MIN);
    localparam logic [7:0]      c_SMAX       = 8'(SWEEP_MAX);
    localparam logic [7:0]      c_DEG_RST    = 8'(DEG_RESET);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_TRACK      = 2'd1,
        S_SWEEP_UP   = 2'd2,
        S_SWEEP_DOWN = 2'd3
    } state_t;

    state_t                r_state, w_state_n;
    logic [c_PW-1:0]       r_presc, w_presc_n;
    logic [CNTR_WIDTH-1:0] r_cntr,  w_cntr_n;
    logic [7:0]            r_deg,   w_deg_n;
    logic [7:0]            r_active, w_active_n;
    logic                  r_pend,  w_pend_n;
    logic [7:0]            r_pend_deg, w_pend_deg_n;
    logic                  r_en,    w_en_n;
    logic                  r_fs,    w_fs_n;
    logic                  r_at,    w_at_n;

    logic                  w_tick;
    logic                  w_boundary;
    logic [7:0]            w_tgt;
    logic [7:0]            w_trk_deg;
    logic [7:0]            w_up_deg;
    logic                  w_up_turn;
    logic [7:0]            w_dn_deg;
    logic                  w_dn_turn;

    assign w_tick     = (r_presc == c_PRESC_LAST);
    assign w_boundary = w_tick && (r_cntr == {CNTR_WIDTH{1'b1}});
    // A pending target becomes active at the boundary, so the step is aimed at it.
    assign w_tgt      = r_pend ? r_pend_deg : r_active;

    // Per-frame position candidates. Comparisons are done on widened values so
    // the +/-STEP never wraps; the selected 8-bit result is always in range.
    always_comb begin
        w_trk_deg = r_deg;
        w_up_deg  = r_deg;
        w_up_turn = 1'b0;
        w_dn_deg  = r_deg;
        w_dn_turn = 1'b0;

        if (w_tgt > r_deg) begin
            if ({2'b00, r_deg} + c_STEP10 >= {2'b00, w_tgt}) w_trk_deg = w_tgt;
            else                                             w_trk_deg = r_deg + c_STEP8;
        end else if (w_tgt < r_deg) begin
            if ({2'b00, r_deg} <= {2'b00, w_tgt} + c_STEP10) w_trk_deg = w_tgt;
            else                                             w_trk_deg = r_deg - c_STEP8;
        end

        // Below-range entry clamps up to SWEEP_MIN and keeps rising.
        if (r_deg < c_SMIN) begin
            w_up_deg = c_SMIN;
        end else if ({2'b00, r_deg} + c_STEP10 >= {2'b00, c_SMAX}) begin
            w_up_deg  = c_SMAX;
            w_up_turn = 1'b1;
        end else begin
            w_up_deg = r_deg + c_STEP8;
        end

        // Above-range entry clamps down to SWEEP_MAX and keeps falling.
        if (r_deg > c_SMAX) begin
            w_dn_deg = c_SMAX;
        end else if ({2'b00, r_deg} <= {2'b00, c_SMIN} + c_STEP10) begin
            w_dn_deg  = c_SMIN;
            w_dn_turn = 1'b1;
        end else begin
            w_dn_deg = r_deg - c_STEP8;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_presc_n    = r_presc;
        w_cntr_n     = r_cntr;
        w_deg_n      = r_deg;
        w_active_n   = r_active;
        w_pend_n     = r_pend;
        w_pend_deg_n = r_pend_deg;
        w_en_n       = r_en;
        w_fs_n       = 1'b0;
        w_at_n       = r_at;

        if (r_state == S_IDLE) begin
            w_presc_n = '0;
            w_cntr_n  = '0;
            w_en_n    = 1'b0;
            w_at_n    = 1'b0;
            if (run) begin
                w_state_n = sweep ? S_SWEEP_UP : S_TRACK;
                w_en_n    = 1'b1;
            end
        end else if (!run) begin
            w_state_n = S_IDLE;
            w_presc_n = '0;
            w_cntr_n  = '0;
            w_en_n    = 1'b0;
            w_at_n    = 1'b0;
        end else begin
            w_presc_n = w_tick ? '0 : r_presc + c_PW'(1);
            if (w_tick) w_cntr_n = r_cntr + CNTR_WIDTH'(1);
            if (w_boundary) begin
                w_fs_n = 1'b1;
                case (r_state)
                    S_TRACK: begin
                        if (sweep) begin
                            // Mode change only; position moves from the next frame.
                            w_state_n = S_SWEEP_UP;
                            w_at_n    = 1'b0;
                        end else begin
                            w_active_n = w_tgt;
                            w_pend_n   = 1'b0;
                            w_deg_n    = w_trk_deg;
                            w_at_n     = (w_trk_deg == w_tgt);
                        end
                    end
                    S_SWEEP_UP: begin
                        if (!sweep) begin
                            w_state_n  = S_TRACK;
                            w_active_n = r_deg;
                            w_at_n     = 1'b1;
                        end else begin
                            w_deg_n = w_up_deg;
                            if (w_up_turn) w_state_n = S_SWEEP_DOWN;
                        end
                    end
                    default: begin
                        if (!sweep) begin
                            w_state_n  = S_TRACK;
                            w_active_n = r_deg;
                            w_at_n     = 1'b1;
                        end else begin
                            w_deg_n = w_dn_deg;
                            if (w_dn_turn) w_state_n = S_SWEEP_UP;
                        end
                    end
                endcase
            end
        end

        // Buffer accepts whenever empty; consumption above needs it full, so the
        // two never collide and a boundary-cycle transfer waits a whole frame.
        if (tgt_valid && !r_pend) begin
            w_pend_n     = 1'b1;
            w_pend_deg_n = tgt_deg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_cntr     <= '0;
            r_deg      <= c_DEG_RST;
            r_active   <= c_DEG_RST;
            r_pend     <= 1'b0;
            r_pend_deg <= '0;
            r_en       <= 1'b0;
            r_fs       <= 1'b0;
            r_at       <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_presc    <= w_presc_n;
            r_cntr     <= w_cntr_n;
            r_deg      <= w_deg_n;
            r_active   <= w_active_n;
            r_pend     <= w_pend_n;
            r_pend_deg <= w_pend_deg_n;
            r_en       <= w_en_n;
            r_fs       <= w_fs_n;
            r_at       <= w_at_n;
        end
    end

    assign tgt_ready   = ~r_pend;
    assign cntr        = r_cntr;
    assign deg         = r_deg;
    assign en          = r_en;
    assign frame_start = r_fs;
    assign at_target   = r_at;

endmodule

`default_nettype wire

// File: tb/tb_servo_frame_ctrl.sv
// ============================================================================
//  Module   : tb_servo_frame_ctrl
//  Purpose  : Self-checking bench for servo_frame_ctrl. Two instances (STEP=1
//             and STEP=100) share one stimulus stream; a frame-level model of
//             each is compared every cycle, plus literal scenario checks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_servo_frame_ctrl;

    localparam int c_CW    = 4;
    localparam int c_CD    = 2;
    localparam int c_FRAME = c_CD * (1 << c_CW);
    localparam int c_SMIN  = 0;
    localparam int c_SMAX  = 255;

    logic       clk = 1'b0;
    logic       rst, run, sweep, tgt_valid;
    logic [7:0] tgt_deg;

    logic             a_rdy, a_en, a_fs, a_at;
    logic [c_CW-1:0]  a_cntr;
    logic [7:0]       a_deg;
    logic             b_rdy, b_en, b_fs, b_at;
    logic [c_CW-1:0]  b_cntr;
    logic [7:0]       b_deg;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    servo_frame_ctrl #(.CNTR_WIDTH(c_CW), .CLK_DIV(c_CD), .STEP(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .run(run), .sweep(sweep), .tgt_deg(tgt_deg),
        .tgt_valid(tgt_valid), .tgt_ready(a_rdy), .cntr(a_cntr), .deg(a_deg),
        .en(a_en), .frame_start(a_fs), .at_target(a_at));

    servo_frame_ctrl #(.CNTR_WIDTH(c_CW), .CLK_DIV(c_CD), .STEP(100)) u_dut_s100 (
        .clk(clk), .rst(rst), .run(run), .sweep(sweep), .tgt_deg(tgt_deg),
        .tgt_valid(tgt_valid), .tgt_ready(b_rdy), .cntr(b_cntr), .deg(b_deg),
        .en(b_en), .frame_start(b_fs), .at_target(b_at));

    // ---------------- behavioural model (index 0: STEP=1, 1: STEP=100) -------
    // mode: 0 idle, 1 track, 2 sweep up, 3 sweep down
    int m_step [2] = '{1, 100};
    int m_mode [2], m_el [2], m_deg [2], m_act [2], m_pend [2], m_pd [2];
    int m_fs [2], m_at [2];
    bit m_init = 1'b0;

    task automatic model_frame(input int i);
        int d, n;
        case (m_mode[i])
            1: begin
                if (sweep) begin
                    m_mode[i] = 2; m_at[i] = 0;
                end else begin
                    if (m_pend[i] != 0) begin m_act[i] = m_pd[i]; m_pend[i] = 0; end
                    d = m_act[i] - m_deg[i];
                    if (d > 0)      m_deg[i] += (d < m_step[i]) ? d : m_step[i];
                    else if (d < 0) m_deg[i] -= (-d < m_step[i]) ? -d : m_step[i];
                    m_at[i] = (m_deg[i] == m_act[i]) ? 1 : 0;
                end
            end
            2: begin
                if (!sweep) begin
                    m_mode[i] = 1; m_act[i] = m_deg[i]; m_at[i] = 1;
                end else if (m_deg[i] < c_SMIN) begin
                    m_deg[i] = c_SMIN;
                end else begin
                    n = m_deg[i] + m_step[i];
                    if (n >= c_SMAX) begin n = c_SMAX; m_mode[i] = 3; end
                    m_deg[i] = n;
                end
            end
            default: begin
                if (!sweep) begin
                    m_mode[i] = 1; m_act[i] = m_deg[i]; m_at[i] = 1;
                end else if (m_deg[i] > c_SMAX) begin
                    m_deg[i] = c_SMAX;
                end else begin
                    n = m_deg[i] - m_step[i];
                    if (n <= c_SMIN) begin n = c_SMIN; m_mode[i] = 2; end
                    m_deg[i] = n;
                end
            end
        endcase
    endtask

    task automatic model_clock(input int i);
        int acc;
        if (rst) begin
            m_mode[i] = 0; m_el[i] = 0; m_deg[i] = 128; m_act[i] = 128;
            m_pend[i] = 0; m_pd[i] = 0; m_fs[i] = 0; m_at[i] = 0;
            m_init = 1'b1;
            return;
        end
        acc = (tgt_valid && m_pend[i] == 0) ? 1 : 0;
        m_fs[i] = 0;
        if (m_mode[i] == 0) begin
            m_el[i] = 0; m_at[i] = 0;
            if (run) m_mode[i] = sweep ? 2 : 1;
        end else if (!run) begin
            m_mode[i] = 0; m_el[i] = 0; m_at[i] = 0;
        end else begin
            m_el[i]++;
            if (m_el[i] % c_FRAME == 0) begin
                m_fs[i] = 1;
                model_frame(i);
            end
        end
        if (acc != 0) begin m_pend[i] = 1; m_pd[i] = tgt_deg; end
    endtask

    always begin
        @(posedge clk);
        model_clock(0);
        model_clock(1);
    end

    task automatic cmp(input int i, input int cn, input int dg, input int e,
                       input int fs, input int at, input int rd);
        int xc, xe;
        xe = (m_mode[i] != 0) ? 1 : 0;
        xc = (m_mode[i] == 0) ? 0 : (m_el[i] / c_CD) % (1 << c_CW);
        checks++;
        if (cn != xc || dg != m_deg[i] || e != xe || fs != m_fs[i] ||
            at != m_at[i] || rd != (m_pend[i] == 0 ? 1 : 0)) begin
            failures++;
            $display("FAIL model_u%0d t=%0t got cntr=%0d deg=%0d en=%0d fs=%0d at=%0d rdy=%0d exp cntr=%0d deg=%0d en=%0d fs=%0d at=%0d rdy=%0d",
                     i, $time, cn, dg, e, fs, at, rd, xc, m_deg[i], xe, m_fs[i], m_at[i],
                     (m_pend[i] == 0) ? 1 : 0);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (m_init) begin
            cmp(0, int'(a_cntr), int'(a_deg), int'(a_en), int'(a_fs), int'(a_at), int'(a_rdy));
            cmp(1, int'(b_cntr), int'(b_deg), int'(b_en), int'(b_fs), int'(b_at), int'(b_rdy));
        end
    end

    // ---------------- literal checks -----------------------------------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_fs && n < 200);
        if (!a_fs) chk("frame_start_timeout", 0, 1);
    endtask

    initial begin
        int n, d0, k;
        rst = 1'b1; run = 1'b0; sweep = 1'b0; tgt_valid = 1'b0; tgt_deg = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_deg", int'(a_deg), 128);
        chk("rst_ready", int'(a_rdy), 1);
        chk("rst_en", int'(a_en), 0);
        chk("rst_cntr", int'(a_cntr), 0);
        chk("rst_at", int'(a_at), 0);

        // start tracking, offer 131
        rst = 1'b0; run = 1'b1;
        @(negedge clk);
        chk("en_after_run", int'(a_en), 1);
        chk("cntr_after_run", int'(a_cntr), 0);
        tgt_valid = 1'b1; tgt_deg = 8'd131;
        @(negedge clk);
        tgt_valid = 1'b0;
        chk("ready_while_pending", int'(a_rdy), 0);
        wait_fs(n);
        chk("trk_b1_deg", int'(a_deg), 129);
        chk("trk_b1_ready", int'(a_rdy), 1);
        chk("trk_b1_cntr", int'(a_cntr), 0);
        chk("trk_s100_deg", int'(b_deg), 131);
        chk("trk_s100_at", int'(b_at), 1);
        wait_fs(n);
        chk("frame_period", n, 32);
        chk("trk_b2_deg", int'(a_deg), 130);
        chk("trk_b2_at", int'(a_at), 0);
        wait_fs(n);
        chk("trk_b3_deg", int'(a_deg), 131);
        chk("trk_b3_at", int'(a_at), 1);

        // target offered exactly on a boundary cycle, then a second offer
        repeat (31) @(negedge clk);
        tgt_valid = 1'b1; tgt_deg = 8'd125;
        @(negedge clk);
        chk("bnd_fs", int'(a_fs), 1);
        chk("bnd_deg_held", int'(a_deg), 131);
        chk("bnd_ready", int'(a_rdy), 0);
        tgt_deg = 8'd200;
        @(negedge clk);
        tgt_valid = 1'b0;
        chk("second_offer_ready", int'(a_rdy), 0);
        wait_fs(n);
        chk("bnd_next_deg", int'(a_deg), 130);
        chk("bnd_next_ready", int'(a_rdy), 1);
        wait_fs(n);
        chk("second_offer_dropped", int'(a_deg), 129);

        // run=0 at cntr=7
        k = 0;
        while (a_cntr != 4'd7 && k < 100) begin @(negedge clk); k++; end
        chk("reach_cntr7", int'(a_cntr), 7);
        d0 = int'(a_deg);
        run = 1'b0;
        @(negedge clk);
        chk("stop_cntr", int'(a_cntr), 0);
        chk("stop_en", int'(a_en), 0);
        chk("stop_deg", int'(a_deg), d0);
        run = 1'b1;
        @(negedge clk);
        chk("restart_en", int'(a_en), 1);
        chk("restart_cntr", int'(a_cntr), 0);
        repeat (2) @(negedge clk);
        chk("restart_cntr1", int'(a_cntr), 1);

        // sweep from 128 with STEP=100
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; sweep = 1'b1; run = 1'b1;
        wait_fs(n); chk("swp_1", int'(b_deg), 228);
        wait_fs(n); chk("swp_2", int'(b_deg), 255);
        wait_fs(n); chk("swp_3", int'(b_deg), 155);
        wait_fs(n); chk("swp_4", int'(b_deg), 55);
        wait_fs(n); chk("swp_5", int'(b_deg), 0);
        chk("swp_at", int'(b_at), 0);

        // reset pulse mid-sweep with an offer in the reset cycle
        repeat (10) @(negedge clk);
        rst = 1'b1; tgt_valid = 1'b1; tgt_deg = 8'd77;
        @(negedge clk);
        rst = 1'b0; tgt_valid = 1'b0;
        chk("midrst_deg", int'(b_deg), 128);
        chk("midrst_ready", int'(b_rdy), 1);
        chk("midrst_en", int'(b_en), 0);

        // randomized phase
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 999) < 2);
            if (run && $urandom_range(0, 399) == 0)       run = 1'b0;
            else if (!run && $urandom_range(0, 7) == 0)   run = 1'b1;
            if ($urandom_range(0, 149) == 0)              sweep = ~sweep;
            tgt_valid = ($urandom_range(0, 3) == 0);
            tgt_deg   = 8'($urandom);
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
